// File: rtl/counter_ctrl_if.sv
// Command, status and downstream-counter signals of counter_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface counter_ctrl_if #(
   parameter int unsigned WIDTH  = 5,
   parameter int unsigned PASS_W = 8
);
   logic              start;
   logic [WIDTH-1:0]  start_val;
   logic [WIDTH-1:0]  end_val;
   logic              auto_reload;
   logic              stop;
   logic [WIDTH-1:0]  cnt_out;
   logic              load;
   logic              enable;
   logic [WIDTH-1:0]  cnt_in;
   logic              busy;
   logic              done;
   logic [PASS_W-1:0] passes;

   modport slave (
      input  start, start_val, end_val, auto_reload, stop, cnt_out,
      output load, enable, cnt_in, busy, done, passes
   );

   modport master (
      output start, start_val, end_val, auto_reload, stop, cnt_out,
      input  load, enable, cnt_in, busy, done, passes
   );
endinterface

// File: rtl/counter_ctrl.sv
// Sequencing controller for a loadable up-counter: one start runs a count
// from a latched start value to a latched end value, optionally reloading.
module counter_ctrl #(
   parameter int unsigned WIDTH  = 5,
   parameter int unsigned PASS_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   counter_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [WIDTH-1:0]  start_q;
   logic [WIDTH-1:0]  end_q;
   logic              reload_q;
   logic              done_q;
   logic [PASS_W-1:0] passes_q;
   logic              latch_en;
   logic              pass_inc;
   logic              match;

   assign match = (bus.cnt_out == end_q);

   // Next-state logic; stop takes priority over a terminal-count match.
   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      pass_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               latch_en = 1'b1;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            state_d = bus.stop ? IDLE : RUN;
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (match) begin
               pass_inc = 1'b1;
               state_d  = reload_q ? LOAD : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Enable drops combinationally on match so the counter holds the end value.
   assign bus.load   = (state_q == LOAD);
   assign bus.enable = (state_q == LOAD) | ((state_q == RUN) & ~match & ~bus.stop);
   assign bus.busy   = (state_q != IDLE);
   assign bus.cnt_in = start_q;
   assign bus.done   = done_q;
   assign bus.passes = passes_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         start_q  <= '0;
         end_q    <= '0;
         reload_q <= 1'b0;
         done_q   <= 1'b0;
         passes_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= pass_inc;
         if (latch_en) begin
            start_q  <= bus.start_val;
            end_q    <= bus.end_val;
            reload_q <= bus.auto_reload;
            passes_q <= '0;
         end else if (pass_inc && (passes_q != {PASS_W{1'b1}})) begin
            passes_q <= passes_q + PASS_W'(1);
         end
      end
   end
endmodule
